// File: rtl/osc_sequencer_if.sv
// Coefficient-set handshake between the host register block and osc_sequencer.
interface osc_sequencer_if #(
  parameter int DIV_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [31:0]      cfg_sinx;
  logic [31:0]      cfg_cos2x;
  logic [2:0]       cfg_mode;
  logic [DIV_W-1:0] cfg_div;

  modport master (output cfg_valid, cfg_sinx, cfg_cos2x, cfg_mode, cfg_div,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_sinx, cfg_cos2x, cfg_mode, cfg_div,
                  output cfg_ready);
endinterface

// File: rtl/osc_sequencer.sv
// Control front-end for the recursive sine oscillator: loads coefficient sets,
// primes and paces the oscillator, and supervises run-time frequency changes.
module osc_sequencer #(
  parameter int DIV_W = 16,
  parameter int TMO_W = 12
) (
  input  logic             Fg_CLK,
  input  logic             RESETn,
  osc_sequencer_if.slave   cfg,
  input  logic             start,
  input  logic             stop,
  input  logic [TMO_W-1:0] tmo_limit,
  input  logic [31:0]      osc_out2,
  output logic             osc_Ready,
  output logic             osc_Enable,
  output logic             osc_FreqChng,
  output logic [2:0]       osc_mode,
  output logic [31:0]      osc_sinx,
  output logic [31:0]      osc_cos2x,
  output logic             running,
  output logic             chg_done,
  output logic             chg_err
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, CHG_WAIT} state_t;

  state_t           state_q, state_d;
  logic             loaded_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [TMO_W-1:0] tmo_q;
  logic             chk_q;

  logic ready_c, accept, active, enable_c, done_c, timeout_c;

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A stop in the same cycle withdraws ready so the host never sees a dropped set as taken.
  always_comb begin
    state_d   = state_q;
    done_c    = 1'b0;
    timeout_c = 1'b0;
    active    = (state_q == RUN) || (state_q == CHG_WAIT);
    enable_c  = active && (cnt_q == div_q);
    ready_c   = ((state_q == IDLE) || (state_q == RUN)) && !stop;
    accept    = cfg.cfg_valid && ready_c;
    case (state_q)
      IDLE:     if (!accept && start && loaded_q) state_d = PRIME;
      PRIME:    state_d = RUN;
      RUN:      if (accept) state_d = CHG_WAIT;
      CHG_WAIT: begin
        if (chk_q && !stop) begin
          if (osc_out2 == 32'd0) begin
            done_c  = 1'b1;
            state_d = RUN;
          end else if (tmo_q >= tmo_limit) begin
            timeout_c = 1'b1;
            state_d   = RUN;
          end
        end
      end
      default:  state_d = IDLE;
    endcase
    if (stop) state_d = IDLE;
  end

  assign cfg.cfg_ready = ready_c;
  assign osc_Ready     = (state_q == PRIME);
  assign osc_Enable    = enable_c;
  assign running       = (state_q != IDLE);
  assign chg_done      = done_c;

  // chk_q marks the cycle after a strobe issued while waiting; only then is Out2 trusted.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      loaded_q     <= 1'b0;
      div_q        <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      chk_q        <= 1'b0;
      osc_FreqChng <= 1'b0;
      osc_mode     <= '0;
      osc_sinx     <= '0;
      osc_cos2x    <= '0;
      chg_err      <= 1'b0;
    end else begin
      osc_FreqChng <= accept && (state_q == RUN);
      chk_q        <= (state_q == CHG_WAIT) && enable_c && !stop;

      if (accept) begin
        osc_sinx  <= cfg.cfg_sinx;
        osc_cos2x <= cfg.cfg_cos2x;
        osc_mode  <= cfg.cfg_mode;
        div_q     <= cfg.cfg_div;
        loaded_q  <= 1'b1;
      end

      if (!active || (state_d == IDLE) || accept || enable_c) cnt_q <= '0;
      else                                                     cnt_q <= cnt_q + DIV_W'(1);

      if (accept)                                 tmo_q <= '0;
      else if ((state_q == CHG_WAIT) && enable_c) tmo_q <= tmo_q + TMO_W'(1);

      if (stop)           chg_err <= 1'b0;
      else if (timeout_c) chg_err <= 1'b1;
    end
  end

endmodule
